// File: rtl/elastic_skid_fifo_if.sv
// Valid/ready stream bundle around the elastic skid FIFO.
// The _f signals face the producer and the _b signals face the consumer.
interface elastic_skid_fifo_if #(
    parameter int L = 8
);
    logic         ready_f;
    logic         valid_f;
    logic [L-1:0] data_f;
    logic         ready_b;
    logic         valid_b;
    logic [L-1:0] data_b;

    modport master (
        input  ready_f,
        output valid_f,
        output data_f,
        output ready_b,
        input  valid_b,
        input  data_b
    );

    modport slave (
        output ready_f,
        input  valid_f,
        input  data_f,
        input  ready_b,
        output valid_b,
        output data_b
    );
endinterface

// File: rtl/elastic_skid_fifo.sv
// DEPTH-entry elastic buffer: a registered output word backed by a (DEPTH-1)-entry ring.
// All outputs come from flops, so no combinational path crosses the block.
module elastic_skid_fifo #(
    parameter  int L        = 8,
    parameter  int DEPTH    = 4,
    parameter  int AFULL_TH = 3,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    elastic_skid_fifo_if.slave    bus,
    input  logic                  flush,
    output logic [CW-1:0]         count,
    output logic                  afull
);
    localparam int SD = DEPTH - 1;
    localparam int PW = (SD > 1) ? $clog2(SD) : 1;

    logic [L-1:0]  mem [SD];
    logic          ready_f_r;
    logic          valid_b_r;
    logic [L-1:0]  data_b_r;
    logic [CW-1:0] count_r;
    logic          afull_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;

    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic          st_empty_s;
    logic          wr_en_s;
    logic [CW-1:0] count_next_s;
    logic          valid_b_next_s;
    logic [L-1:0]  data_b_next_s;
    logic [PW-1:0] rd_next_s;
    logic [PW-1:0] wr_next_s;
    logic          ready_f_next_s;
    logic          afull_next_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(SD - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    assign push_s     = bus.valid_f && ready_f_r;
    assign pop_s      = valid_b_r && bus.ready_b;
    assign load_s     = !valid_b_r || pop_s;
    // The output register holds one of the counted words whenever it is valid.
    assign st_empty_s = ((count_r - CW'(valid_b_r)) == {CW{1'b0}});

    // Next-state for output register, ring pointers, occupancy and flags.
    always_comb begin
        count_next_s   = count_r + CW'(push_s) - CW'(pop_s);
        valid_b_next_s = valid_b_r;
        data_b_next_s  = data_b_r;
        rd_next_s      = rd_ptr_r;
        wr_next_s      = wr_ptr_r;
        wr_en_s        = 1'b0;
        if (flush) begin
            count_next_s   = {CW{1'b0}};
            valid_b_next_s = 1'b0;
            rd_next_s      = {PW{1'b0}};
            wr_next_s      = {PW{1'b0}};
        end else begin
            if (load_s) begin
                if (!st_empty_s) begin
                    data_b_next_s  = mem[rd_ptr_r];
                    valid_b_next_s = 1'b1;
                    rd_next_s      = ptr_inc(rd_ptr_r);
                end else if (push_s) begin
                    data_b_next_s  = bus.data_f;
                    valid_b_next_s = 1'b1;
                end else begin
                    valid_b_next_s = 1'b0;
                end
            end else begin
                valid_b_next_s = valid_b_r;
            end
            // A push bypasses the ring only when it goes straight into an emptying output.
            if (push_s && !(load_s && st_empty_s)) begin
                wr_en_s   = 1'b1;
                wr_next_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_en_s = 1'b0;
            end
        end
        ready_f_next_s = (count_next_s != CW'(DEPTH));
        afull_next_s   = (count_next_s >= CW'(AFULL_TH));
    end

    // Ring storage write port.
    always_ff @(posedge clk) begin
        if (rst && wr_en_s) begin
            mem[wr_ptr_r] <= bus.data_f;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_f_r <= 1'b0;
            valid_b_r <= 1'b0;
            data_b_r  <= {L{1'b0}};
            count_r   <= {CW{1'b0}};
            afull_r   <= 1'b0;
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
        end else begin
            ready_f_r <= ready_f_next_s;
            valid_b_r <= valid_b_next_s;
            data_b_r  <= data_b_next_s;
            count_r   <= count_next_s;
            afull_r   <= afull_next_s;
            rd_ptr_r  <= rd_next_s;
            wr_ptr_r  <= wr_next_s;
        end
    end

    assign bus.ready_f = ready_f_r;
    assign bus.valid_b = valid_b_r;
    assign bus.data_b  = data_b_r;
    assign count       = count_r;
    assign afull       = afull_r;
endmodule

// File: doc/elastic_skid_fifo.md
# elastic_skid_fifo

Parametrised successor to the single-entry backward skid buffer: a DEPTH-entry elastic buffer on a valid/ready stream with registered `ready_f`, registered `valid_b`/`data_b`, an occupancy count, an almost-full flag and a synchronous flush. It sits between a producer on the `_f` side and a consumer on the `_b` side. It breaks every combinational path in both directions and sustains one word per cycle under arbitrary backpressure.

## Interface
- `L`, 8, data width in bits (≥1)
- `DEPTH`, 4, total capacity in words, output register included (≥2)
- `AFULL_TH`, 3, almost-full threshold (1..DEPTH)
- `clk` input 1 — single clock, all logic on rising edge
- `rst` input 1 — synchronous reset, active-low
- `ready_f` output 1 — registered; buffer can accept a word this cycle
- `valid_f` input 1 — upstream word valid
- `data_f` input L — upstream data
- `ready_b` input 1 — downstream can accept
- `valid_b` output 1 — registered; `data_b` holds a valid word
- `data_b` output L — registered head-of-queue data
- `flush` input 1 — synchronous discard of all contents
- `count` output $clog2(DEPTH+1) — registered occupancy, output register included
- `afull` output 1 — registered, `count >= AFULL_TH`

## Operation
- Push = `valid_f && ready_f`. Pop = `valid_b && ready_b`. `count_next = count + push - pop`.
- `ready_f` is a flop loaded with `count_next != DEPTH`. It never asserts while full, so no word is lost and no extra skid entry is needed.
- Storage is the output register plus a (DEPTH-1)-entry circular array with read/write pointers that wrap modulo DEPTH-1.
- Output register load, applied when it is empty or being popped:
  - storage non-empty → load the storage head and advance the read pointer;
  - else if push → load `data_f` directly (bypass);
  - else → `valid_b` goes to 0.
- Any push not consumed by the bypass is written to storage at the write pointer.
- Words leave in strict arrival order. No duplication, no drops except on flush.
- While `valid_b && !ready_b`, `data_b` and `valid_b` must hold stable.
- When `valid_b = 0`, `data_b` holds its last value.
- `flush = 1` has priority over push and pop at the edge. The next cycle shows `count = 0`, `valid_b = 0`, `ready_f = 1`, `afull = 0`, and both pointers at 0.
  - A push offered in the flush cycle is discarded.
  - A pop in the flush cycle is treated as completed by the consumer; the word is removed.
- `afull` is a flop loaded with `count_next >= AFULL_TH`, using the flush-adjusted count.

## Timing
- Reset (`rst = 0` at an edge): `ready_f = 0`, `valid_b = 0`, `data_b = 0`, `count = 0`, `afull = 0`, pointers 0.
- The first edge with `rst = 1` sets `ready_f = 1`. Reset in mid-stream drops all contents identically.
- Latency, empty buffer: a word pushed at edge k is on `data_b` with `valid_b = 1` after edge k (one cycle).
- Throughput: one word per cycle with `ready_b` held high, at any occupancy.
- Full with a pop at edge k: `ready_f` rises after edge k. The earliest refill push is at edge k+1.
- Full with `ready_b = 0`: `ready_f = 0` and the outputs are frozen.
- Push and pop in the same cycle: `count` is unchanged and `ready_f` is unchanged.
- `count` and `afull` change only at edges. Both reflect `count_next`.

## Test plan
1. **Reset.**
   - Stimulus: `rst = 0` for 3 cycles with `valid_f = 1`, `data_f = 0x55`.
   - Required: `valid_b = 0`, `data_b = 0x00`, `ready_f = 0`, `count = 0`, `afull = 0` throughout.
   - Required: `ready_f = 1` after the first edge with `rst = 1`, and no word captured during reset.
2. **Fill (DEPTH = 4, AFULL_TH = 3).**
   - Stimulus: `ready_b = 0`; push 0x11, 0x12, 0x13, 0x14 on consecutive cycles.
   - Required: `count` steps 1→2→3→4.
   - Required: `valid_b = 1` with `data_b = 0x11` after the first edge.
   - Required: `afull = 1` after the 3rd push and `ready_f = 0` after the 4th.
   - Required: outputs stay frozen while `ready_b = 0`.
3. **Drain from full under continuous input.**
   - Stimulus: from the test 2 state, `ready_b = 1` while offering 0x15 onward every cycle.
   - Required: output sequence 0x11, 0x12, 0x13, 0x14, 0x15, … with no gaps.
   - Required: `ready_f = 1` one cycle after the first pop, and the 0x15 push accepted the cycle after that.
4. **Streaming bypass.**
   - Stimulus: buffer empty, `ready_b = 1`; push 0xA0–0xAF on 16 consecutive cycles.
   - Required: each word appears one cycle after its push, 16 consecutive valid beats.
   - Required: `count` stays at 1 and `afull` stays 0.
5. **Flush.**
   - Stimulus: `count = 3`, `flush = 1` together with push 0x77.
   - Required: the next cycle shows `count = 0`, `valid_b = 0`, `ready_f = 1`, `afull = 0`.
   - Required: 0x77 never appears on `data_b`.
   - Required: a following push of 0x78 appears one cycle later.
6. **Random backpressure.**
   - Stimulus: 1000 words, random `valid_f` and `ready_b` (50%), scoreboard on the output.
   - Required: order preserved, no loss or duplication.
   - Required: `data_b` stable while stalled and `count` always matches the model.
